jt12_mod_src: RTL

// Slot sequencer and modulation-source datapath for the FM operator pipeline.

---
 rtl/jt12_mod_src.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/jt12_mod_src.sv
// Slot sequencer and modulation-source datapath for the FM operator pipeline.
// Walks the 24 operator slots and produces the registered phase-modulation value per slot.
module jt12_mod_src #(
  parameter int OPW = 14,
  parameter int PMW = 15,
  parameter int NCH = 6
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  zero,
  input  logic [2:0]            fb_I,
  input  logic                  use_prevprev1,
  input  logic                  use_prev1,
  input  logic                  use_prev2,
  input  logic                  use_internal_x,
  input  logic                  use_internal_y,
  input  logic                  op_we,
  input  logic [2:0]            op_ch,
  input  logic [1:0]            op_grp,
  input  logic signed [OPW-1:0] op_data,
  output logic                  s1_enters,
  output logic                  s2_enters,
  output logic                  s3_enters,
  output logic                  s4_enters,
  output logic [2:0]            cur_ch,
  output logic signed [PMW-1:0] pm_out,
  output logic                  pm_valid
);

  localparam int SW = 16;
  localparam logic [2:0] LAST_CH = 3'(NCH - 1);
  localparam logic [3:0] NCH_W = 4'(NCH);
  localparam logic signed [SW-1:0] PM_MAX = SW'((1 <<< (PMW - 1)) - 1);
  localparam logic signed [SW-1:0] PM_MIN = SW'(-(1 <<< (PMW - 1)));

  function automatic logic signed [SW-1:0] ext_sw(input logic signed [OPW-1:0] x);
    return {{(SW - OPW){x[OPW-1]}}, x};
  endfunction

  function automatic logic signed [PMW-1:0] ext_pm(input logic signed [OPW-1:0] x);
    return {{(PMW - OPW){x[OPW-1]}}, x};
  endfunction

  // Slot counter: channel is the fast index, group advances on channel wrap
  logic [2:0] ch_reg;
  logic [1:0] grp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_reg  <= '0;
      grp_reg <= '0;
    end else if (clk_en) begin
      if (zero) begin
        ch_reg  <= '0;
        grp_reg <= '0;
      end else if (ch_reg == LAST_CH) begin
        ch_reg  <= '0;
        grp_reg <= grp_reg + 2'd1;
      end else begin
        ch_reg <= ch_reg + 3'd1;
      end
    end
  end

  assign s1_enters = (grp_reg == 2'd0);
  assign s3_enters = (grp_reg == 2'd1);
  assign s2_enters = (grp_reg == 2'd2);
  assign s4_enters = (grp_reg == 2'd3);
  assign cur_ch    = ch_reg;

  // History: h_reg[ch][0] doubles as the most recent S1 result (s1_0)
  logic signed [OPW-1:0] h_reg    [NCH][4];
  logic signed [OPW-1:0] s1_1_reg [NCH];
  logic                  wr_en;
  logic [NCH-1:0]        wr_hit;

  assign wr_en = op_we && ({1'b0, op_ch} < NCH_W);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_hit
      assign wr_hit[gi] = wr_en && (op_ch == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int g = 0; g < 4; g++) begin
          h_reg[c][g] <= '0;
        end
        s1_1_reg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_hit[c]) begin
          h_reg[c][op_grp] <= op_data;
          if (op_grp == 2'd0) begin
            s1_1_reg[c] <= h_reg[c][0];
          end
        end
      end
    end
  end

  // Reads see the value each register holds after a same-cycle write
  logic                  rd_same_ch;
  logic signed [OPW-1:0] rd_h [4];
  logic signed [OPW-1:0] rd_s1_1;

  assign rd_same_ch = wr_en && (op_ch == ch_reg);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd
      assign rd_h[gi] = (rd_same_ch && (op_grp == 2'(gi))) ? op_data : h_reg[ch_reg][gi];
    end
  endgenerate

  assign rd_s1_1 = (rd_same_ch && (op_grp == 2'd0)) ? h_reg[ch_reg][0] : s1_1_reg[ch_reg];

  logic signed [OPW-1:0] src_prev1;
  logic signed [OPW-1:0] src_prev2;
  logic signed [OPW-1:0] src_s1_0;
  logic signed [OPW-1:0] src_int_y;

  assign src_prev1 = rd_h[grp_reg - 2'd1];
  assign src_prev2 = rd_h[grp_reg - 2'd2];
  assign src_s1_0  = rd_h[0];
  assign src_int_y = rd_h[1];

  logic signed [PMW-1:0] fb_sum;
  logic [3:0]            fb_shift;
  logic signed [SW-1:0]  mod_sum;
  logic signed [PMW-1:0] pm_next;

  always_comb begin
    fb_sum   = ext_pm(src_s1_0) + ext_pm(rd_s1_1);
    fb_shift = 4'd9 - {1'b0, fb_I};
    mod_sum  = (use_prev1      ? ext_sw(src_prev1) : '0)
             + (use_prev2      ? ext_sw(src_prev2) : '0)
             + (use_prevprev1  ? ext_sw(src_s1_0)  : '0)
             + (use_internal_x ? ext_sw(src_s1_0)  : '0)
             + (use_internal_y ? ext_sw(src_int_y) : '0);
    pm_next  = '0;
    if (grp_reg == 2'd0) begin
      // S1 only ever takes self-feedback from its own last two outputs
      if (use_prev1 && use_prevprev1 && (fb_I != 3'd0)) begin
        pm_next = fb_sum >>> fb_shift;
      end
    end else if (mod_sum > PM_MAX) begin
      pm_next = PM_MAX[PMW-1:0];
    end else if (mod_sum < PM_MIN) begin
      pm_next = PM_MIN[PMW-1:0];
    end else begin
      pm_next = mod_sum[PMW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_out   <= '0;
      pm_valid <= 1'b0;
    end else if (clk_en) begin
      pm_out   <= pm_next;
      pm_valid <= 1'b1;
    end else begin
      pm_valid <= 1'b0;
    end
  end

endmodule
